// File: rtl/matrix_3x3_gen.sv
// Sliding 3x3 window generator for an 8-bit raster stream, built from two line buffers
// and per-row column shift registers, with zero padding at the top and left borders.
module matrix_3x3_gen #(
    parameter int IMG_WIDTH = 640,
    parameter int CNT_W     = 11
) (
    input  logic       video_clk,
    input  logic       rst_n,
    input  logic       per_vs,
    input  logic       per_de,
    input  logic [7:0] per_data,
    output logic       matrix_vs,
    output logic       matrix_de,
    output logic [7:0] matrix11,
    output logic [7:0] matrix12,
    output logic [7:0] matrix13,
    output logic [7:0] matrix21,
    output logic [7:0] matrix22,
    output logic [7:0] matrix23,
    output logic [7:0] matrix31,
    output logic [7:0] matrix32,
    output logic [7:0] matrix33
);

    localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_WIDTH - 1);

    logic              vs_d1;
    logic              de_d1;
    logic              vs_rise;
    logic              de_fall;
    logic [CNT_W-1:0]  col_cnt;
    logic [CNT_W-1:0]  col_addr;
    logic              col_ovf;
    logic              pix_ovf;
    logic [1:0]        row_cnt;
    logic [1:0]        pix_row;
    logic              lb_we;
    logic              lb_we_d1;
    logic [ADDR_W-1:0] lb_addr;
    logic [ADDR_W-1:0] lb_addr_d1;
    logic [7:0]        lb1_mem [IMG_WIDTH];
    logic [7:0]        lb2_mem [IMG_WIDTH];
    logic [7:0]        lb1_q;
    logic [7:0]        lb2_q;
    logic [7:0]        data_d1;
    logic              row1_en;
    logic              row2_en;
    logic [7:0]        t1;
    logic [7:0]        t2;
    logic [7:0]        t3;

    // A frame-sync edge coinciding with a valid pixel makes that pixel (0,0).
    always_comb begin
        vs_rise  = per_vs & ~vs_d1;
        de_fall  = de_d1 & ~per_de;
        col_addr = vs_rise ? '0 : col_cnt;
        pix_ovf  = vs_rise ? 1'b0 : col_ovf;
        pix_row  = vs_rise ? 2'd0 : row_cnt;
        lb_we    = per_de & ~pix_ovf;
        lb_addr  = col_addr[ADDR_W-1:0];
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1      <= 1'b0;
            de_d1      <= 1'b0;
            matrix_vs  <= 1'b0;
            matrix_de  <= 1'b0;
            data_d1    <= '0;
            lb_we_d1   <= 1'b0;
            lb_addr_d1 <= '0;
            row1_en    <= 1'b0;
            row2_en    <= 1'b0;
            col_cnt    <= '0;
            col_ovf    <= 1'b0;
            row_cnt    <= '0;
        end else begin
            vs_d1      <= per_vs;
            de_d1      <= per_de;
            matrix_vs  <= vs_d1;
            matrix_de  <= de_d1;
            data_d1    <= per_data;
            lb_we_d1   <= lb_we;
            lb_addr_d1 <= lb_addr;
            // Upper rows are masked until enough lines exist and for pixels past the line end.
            row1_en    <= per_de & ~pix_ovf & (pix_row != 2'd0);
            row2_en    <= per_de & ~pix_ovf & (pix_row == 2'd2);

            if (per_de) begin
                if (col_addr == COL_MAX) begin
                    col_cnt <= col_addr;
                    col_ovf <= 1'b1;
                end else begin
                    col_cnt <= col_addr + 1'b1;
                    col_ovf <= pix_ovf;
                end
            end else if (vs_rise || de_fall) begin
                col_cnt <= '0;
                col_ovf <= 1'b0;
            end

            if (vs_rise) begin
                row_cnt <= '0;
            end else if (de_fall && (row_cnt != 2'd2)) begin
                row_cnt <= row_cnt + 2'd1;
            end
        end
    end

    // Line buffers: lb1 holds the previous line, lb2 the one before; reads return old data.
    always_ff @(posedge video_clk) begin
        if (lb_we) begin
            lb1_mem[lb_addr] <= per_data;
        end
        if (lb_we_d1) begin
            lb2_mem[lb_addr_d1] <= lb1_q;
        end
        lb1_q <= lb1_mem[lb_addr];
        lb2_q <= lb2_mem[lb_addr];
    end

    always_comb begin
        t1 = row2_en ? lb2_q : 8'd0;
        t2 = row1_en ? lb1_q : 8'd0;
        t3 = data_d1;
    end

    // Clearing the taps between lines gives the left-border zero padding.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix11 <= '0;
            matrix12 <= '0;
            matrix13 <= '0;
            matrix21 <= '0;
            matrix22 <= '0;
            matrix23 <= '0;
            matrix31 <= '0;
            matrix32 <= '0;
            matrix33 <= '0;
        end else if (de_d1) begin
            matrix11 <= matrix12;
            matrix12 <= matrix13;
            matrix13 <= t1;
            matrix21 <= matrix22;
            matrix22 <= matrix23;
            matrix23 <= t2;
            matrix31 <= matrix32;
            matrix32 <= matrix33;
            matrix33 <= t3;
        end else begin
            matrix11 <= '0;
            matrix12 <= '0;
            matrix13 <= '0;
            matrix21 <= '0;
            matrix22 <= '0;
            matrix23 <= '0;
            matrix31 <= '0;
            matrix32 <= '0;
            matrix33 <= '0;
        end
    end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen at IMG_WIDTH=4: window taps, border padding,
// over-long lines, stale RAM after frame sync, and mid-frame reset.
module tb_matrix_3x3_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       per_vs;
    logic       per_de;
    logic [7:0] per_data;
    logic       matrix_vs;
    logic       matrix_de;
    logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic [71:0] taps;

    always #5 clk = ~clk;

    matrix_3x3_gen #(
        .IMG_WIDTH(4),
        .CNT_W    (3)
    ) dut (
        .video_clk(clk),
        .rst_n    (rst_n),
        .per_vs   (per_vs),
        .per_de   (per_de),
        .per_data (per_data),
        .matrix_vs(matrix_vs),
        .matrix_de(matrix_de),
        .matrix11 (m11),
        .matrix12 (m12),
        .matrix13 (m13),
        .matrix21 (m21),
        .matrix22 (m22),
        .matrix23 (m23),
        .matrix31 (m31),
        .matrix32 (m32),
        .matrix33 (m33)
    );

    assign taps = {m11, m12, m13, m21, m22, m23, m31, m32, m33};

    typedef struct {
        int          phase;
        int          idx;
        logic [71:0] exp;
    } vec_t;

    vec_t        tbl[20];
    logic [71:0] cap[128];
    int          cap_n;
    int          base[3];
    int          n_chk;
    int          n_fail;
    logic [1:0]  h1, h2;

    function automatic logic [71:0] w(input int a, input int b, input int c, input int d,
                                      input int e, input int f, input int g, input int h,
                                      input int i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, step an edge, check the 2-clk vs/de delay, capture a valid window.
    task automatic tick(input logic vs, input logic de, input logic [7:0] d);
        per_vs   = vs;
        per_de   = de;
        per_data = d;
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = {vs, de};
        check("vs_de_delay", 72'({matrix_vs, matrix_de}), 72'(h2));
        if (matrix_de) begin
            if (cap_n < 128) begin
                cap[cap_n] = taps;
                cap_n++;
            end
        end else begin
            check("idle_taps_zero", taps, '0);
        end
    endtask

    task automatic send_line(input int b, input int n);
        for (int c = 0; c < n; c++) tick(1'b0, 1'b1, 8'(b + c));
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
    endtask

    task automatic vs_pulse();
        tick(1'b1, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        per_vs   = 1'b0;
        per_de   = 1'b0;
        per_data = 8'd0;
        h1       = '0;
        h2       = '0;
        cap_n    = 0;
        n_chk    = 0;
        n_fail   = 0;

        // Frame 1: P(r,c) = 16r+c+1
        tbl[0]  = '{0, 0,  w(0, 0, 0,   0, 0, 0,     0, 0, 1)};
        tbl[1]  = '{0, 3,  w(0, 0, 0,   0, 0, 0,     2, 3, 4)};
        tbl[2]  = '{0, 4,  w(0, 0, 0,   0, 0, 1,     0, 0, 17)};
        tbl[3]  = '{0, 5,  w(0, 0, 0,   0, 1, 2,     0, 17, 18)};
        tbl[4]  = '{0, 7,  w(0, 0, 0,   2, 3, 4,     18, 19, 20)};
        tbl[5]  = '{0, 8,  w(0, 0, 1,   0, 0, 17,    0, 0, 33)};
        tbl[6]  = '{0, 10, w(1, 2, 3,   17, 18, 19,  33, 34, 35)};
        tbl[7]  = '{0, 13, w(0, 17, 18, 0, 33, 34,   0, 49, 50)};
        tbl[8]  = '{0, 15, w(18, 19, 20, 34, 35, 36, 50, 51, 52)};
        // Frame 2: line0 128+c, line1 144+c (6 px), line2 160+c
        tbl[9]  = '{1, 0,  w(0, 0, 0,   0, 0, 0,     0, 0, 128)};
        tbl[10] = '{1, 2,  w(0, 0, 0,   0, 0, 0,     128, 129, 130)};
        tbl[11] = '{1, 3,  w(0, 0, 0,   0, 0, 0,     129, 130, 131)};
        tbl[12] = '{1, 8,  w(0, 0, 0,   130, 131, 0, 146, 147, 148)};
        tbl[13] = '{1, 9,  w(0, 0, 0,   131, 0, 0,   147, 148, 149)};
        tbl[14] = '{1, 10, w(0, 0, 128, 0, 0, 144,   0, 0, 160)};
        tbl[15] = '{1, 13, w(129, 130, 131, 145, 146, 147, 161, 162, 163)};
        // After mid-frame reset, no frame sync: lines 65+c, 81+c, 97+c
        tbl[16] = '{2, 0,  w(0, 0, 0,   0, 0, 0,     0, 0, 65)};
        tbl[17] = '{2, 3,  w(0, 0, 0,   0, 0, 0,     66, 67, 68)};
        tbl[18] = '{2, 7,  w(0, 0, 0,   66, 67, 68,  82, 83, 84)};
        tbl[19] = '{2, 11, w(66, 67, 68, 82, 83, 84, 98, 99, 100)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_taps", taps, '0);
        check("reset_vs_de", 72'({matrix_vs, matrix_de}), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        vs_pulse();
        base[0] = cap_n;
        for (int r = 0; r < 4; r++) send_line(16 * r + 1, 4);

        vs_pulse();
        base[1] = cap_n;
        send_line(128, 4);
        send_line(144, 6);
        send_line(160, 4);

        vs_pulse();
        send_line(200, 4);
        send_line(216, 4);
        tick(1'b0, 1'b1, 8'd232);
        tick(1'b0, 1'b1, 8'd233);
        rst_n  = 1'b0;
        per_de = 1'b0;
        #1;
        check("async_reset_taps", taps, '0);
        check("async_reset_vs_de", 72'({matrix_vs, matrix_de}), '0);
        h1 = '0;
        h2 = '0;
        @(negedge clk);
        check("held_reset_taps", taps, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);
        base[2] = cap_n;
        send_line(65, 4);
        send_line(81, 4);
        send_line(97, 4);
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 8'd0);

        for (int k = 0; k < 20; k++) begin
            int pos;
            pos = base[tbl[k].phase] + tbl[k].idx;
            if (pos < cap_n) begin
                check($sformatf("taps_ph%0d_idx%0d", tbl[k].phase, tbl[k].idx), cap[pos],
                      tbl[k].exp);
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL taps_ph%0d_idx%0d: got no output (only %0d captured), expected %h",
                         tbl[k].phase, tbl[k].idx, cap_n, tbl[k].exp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
